instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC SHALL default to 32'h0000_0000; it is the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 stall  input  1  downstream hold; when high, instruction outputs SHALL hold.
REQ-005 redirect  input  1  branch/jump/IF_flush redirect request.
REQ-006 redirect_pc  input  32  redirect target, byte address.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  request address, SHALL be stable while imem_req=1 and imem_ready=0.
REQ-009 imem_ready  input  1  data valid on imem_rdata this cycle; handshake completes when imem_req=1 and imem_ready=1.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 opcode_out 6, rs_out 5, rt_out 5, rd_out 5, shamt_out 5, funct_out 6, immed_out 16, jumpoffset_out 26  outputs  decoded fields: [31:26], [25:21], [20:16], [15:11], [10:6], [5:0], [15:0], [25:0].
REQ-012 pc_incr_out  output  32  fetch address of the presented instruction + 4.
REQ-013 instr_valid  output  1  outputs hold a real instruction; 0 = bubble.

Function
REQ-014 FSM states SHALL be IDLE, REQ, FULL; imem_req SHALL be 1 only in REQ.
REQ-015 IDLE SHALL last exactly one cycle after reset release, then go to REQ with imem_addr=pc.
REQ-016 REQ, handshake, stall=0, no redirect: output fields load from imem_rdata, pc_incr_out<=pc+4, instr_valid<=1, pc<=pc+4, stay REQ (zero-wait memory gives one instruction per cycle).
REQ-017 REQ, no handshake, stall=0: instr_valid<=0, field outputs hold.
REQ-018 stall=1 with no redirect: all instruction outputs and instr_valid SHALL hold.
REQ-019 REQ, handshake, stall=1: word and pc+4 SHALL load into a one-entry skid buffer, pc<=pc+4, state to FULL.
REQ-020 FULL, stall=0: skid contents load into outputs with instr_valid<=1, state to REQ; the next request issues the following cycle.
REQ-021 redirect=1 SHALL override stall: instr_valid<=0, skid discarded, FULL or REQ-with-handshake -> REQ with pc<=redirect_pc.
REQ-022 redirect=1 in REQ without handshake: request SHALL continue at the old address; redirect_pc latched, discard flag set; on the completing handshake data is dropped (instr_valid stays 0) and pc<=latched target.
REQ-023 A new redirect while discard is set SHALL overwrite the latched target; the newest target wins.
REQ-024 pc arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 SHALL wrap to 0 with pc_incr_out=0.
REQ-025 pc SHALL not be checked for alignment; redirect_pc bits [1:0] SHALL pass through unchanged.

Reset
REQ-026 rst=1 SHALL immediately, without clk, set all field outputs, pc_incr_out and instr_valid to 0, imem_req=0, pc=RESET_PC, skid and discard cleared, state IDLE.
REQ-027 rst asserted mid-request SHALL drop the outstanding request; a memory response arriving after release SHALL be ignored unless imem_req=1.

Verification
REQ-028 Reset, then zero-wait memory returning 32'h012A4020 at addr 0 -> cycle 2: imem_addr=0; next edge: opcode=0, rs=9, rt=10, rd=8, funct=0x20, pc_incr_out=4, instr_valid=1.
REQ-029 Memory with 2 wait states, stall=0 -> instr_valid pulses 1 every third cycle; imem_addr holds each address until imem_ready.
REQ-030 Handshake at addr 0x10 while stall=1 for 3 cycles -> outputs hold old value, state FULL, imem_req=0; stall drops -> pc_incr_out=0x14, instr_valid=1, next request at 0x14.
REQ-031 redirect=1 to 0x400 with a request at 0x20 pending, ready 2 cycles later -> word from 0x20 dropped (instr_valid=0), next imem_addr=0x400.
REQ-032 redirect with stall=1 and FULL -> instr_valid=0 next edge, skid discarded, imem_addr=redirect_pc.
REQ-033 redirect_pc=32'hFFFF_FFFC, zero-wait fetch -> pc_incr_out=0, next imem_addr=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: request/handshake FSM with a one-entry skid buffer for stalls
// and deferred redirect handling while a request is still outstanding.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [5:0]  opcode_out,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic [4:0]  shamt_out,
    output logic [5:0]  funct_out,
    output logic [15:0] immed_out,
    output logic [25:0] jumpoffset_out,
    output logic [31:0] pc_incr_out,
    output logic        instr_valid
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_incr_q, pc_incr_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_word_q, skid_word_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] target_q, target_d;
    logic        discard_q, discard_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_incr_d   = pc_incr_q;
        valid_d     = valid_q;
        skid_word_d = skid_word_q;
        skid_pc4_d  = skid_pc4_q;
        target_d    = target_q;
        discard_d   = discard_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect) pc_d = redirect_pc;
            end
            REQ: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d      = redirect_pc;
                        discard_d = 1'b0;
                    end else begin
                        // Address must stay stable, so remember the target until completion.
                        target_d  = redirect_pc;
                        discard_d = 1'b1;
                    end
                end else if (discard_q) begin
                    valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d      = target_q;
                        discard_d = 1'b0;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_plus4;
                    if (stall) begin
                        skid_word_d = imem_rdata;
                        skid_pc4_d  = pc_plus4;
                        state_d     = FULL;
                    end else begin
                        instr_d   = imem_rdata;
                        pc_incr_d = pc_plus4;
                        valid_d   = 1'b1;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            FULL: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else if (!stall) begin
                    instr_d   = skid_word_q;
                    pc_incr_d = skid_pc4_q;
                    valid_d   = 1'b1;
                    state_d   = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= 32'd0;
            pc_incr_q   <= 32'd0;
            valid_q     <= 1'b0;
            skid_word_q <= 32'd0;
            skid_pc4_q  <= 32'd0;
            target_q    <= 32'd0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_incr_q   <= pc_incr_d;
            valid_q     <= valid_d;
            skid_word_q <= skid_word_d;
            skid_pc4_q  <= skid_pc4_d;
            target_q    <= target_d;
            discard_q   <= discard_d;
        end
    end

    assign imem_req       = (state_q == REQ);
    assign imem_addr      = pc_q;
    assign opcode_out     = instr_q[31:26];
    assign rs_out         = instr_q[25:21];
    assign rt_out         = instr_q[20:16];
    assign rd_out         = instr_q[15:11];
    assign shamt_out      = instr_q[10:6];
    assign funct_out      = instr_q[5:0];
    assign immed_out      = instr_q[15:0];
    assign jumpoffset_out = instr_q[25:0];
    assign pc_incr_out    = pc_incr_q;
    assign instr_valid    = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed boundary cases followed by randomized stall/redirect/wait
// traffic, checked against an address-stream model through a scoreboard monitor.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [5:0]  opcode_out;
    logic [4:0]  rs_out;
    logic [4:0]  rt_out;
    logic [4:0]  rd_out;
    logic [4:0]  shamt_out;
    logic [5:0]  funct_out;
    logic [15:0] immed_out;
    logic [25:0] jumpoffset_out;
    logic [31:0] pc_incr_out;
    logic        instr_valid;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .opcode_out     (opcode_out),
        .rs_out         (rs_out),
        .rt_out         (rt_out),
        .rd_out         (rd_out),
        .shamt_out      (shamt_out),
        .funct_out      (funct_out),
        .immed_out      (immed_out),
        .jumpoffset_out (jumpoffset_out),
        .pc_incr_out    (pc_incr_out),
        .instr_valid    (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed word at address 0, a hash of the address elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h012A_4020;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pres = 0;
    logic        stall_seen = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr = RST_PC;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Each redirect applied at an edge restarts the expected address stream at its target.
    task automatic step(input logic s, input logic r, input logic [31:0] rpc, input logic rdy);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        imem_ready  = rdy;
        @(posedge clk);
        stall_seen = s;
        if (r && !rst) begin
            exp_q.delete();
            exp_q.push_back(rpc);
        end
        #1;
    endtask

    task automatic restart_stream();
        exp_q.delete();
        exp_q.push_back(RST_PC);
    endtask

    // Monitor: a fresh instruction appears after any edge with stall low and valid high.
    always @(negedge clk) begin
        logic [31:0] w;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("addr_hold", imem_addr, pend_addr);
                chk("req_hold", 32'(imem_req), 32'd1);
            end
            if (instr_valid && !stall_seen) begin
                if (exp_q.size() > 0) exp_addr = exp_q.pop_front();
                w = mem_word(exp_addr);
                chk("fields", {opcode_out, rs_out, rt_out, rd_out, shamt_out, funct_out}, w);
                chk("immed", 32'(immed_out), 32'(w[15:0]));
                chk("jumpoffset", 32'(jumpoffset_out), 32'(w[25:0]));
                chk("pc_incr", pc_incr_out, exp_addr + 32'd4);
                exp_addr = exp_addr + 32'd4;
                n_pres++;
            end
            pend      = imem_req && !imem_ready;
            pend_addr = imem_addr;
        end
    end

    initial begin
        logic        s, r, rdy;
        logic [31:0] rpc;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; imem_ready = 1'b0;
        #2;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc_incr", pc_incr_out, 32'd0);
        chk("rst_fields", {opcode_out, rs_out, rt_out, rd_out, shamt_out, funct_out}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        restart_stream();

        // First fetch from a zero-wait memory.
        step(1'b0, 1'b0, 32'd0, 1'b1);
        #3;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        chk("idle_valid", 32'(instr_valid), 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        #3;
        chk("dec_opcode", 32'(opcode_out), 32'd0);
        chk("dec_rs", 32'(rs_out), 32'd9);
        chk("dec_rt", 32'(rt_out), 32'd10);
        chk("dec_rd", 32'(rd_out), 32'd8);
        chk("dec_funct", 32'(funct_out), 32'h20);
        chk("dec_pc_incr", pc_incr_out, 32'd4);
        chk("dec_valid", 32'(instr_valid), 32'd1);
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Handshake at 0x10 under a three-cycle stall goes to the skid buffer.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b1);
            #3;
            chk("skid_req", 32'(imem_req), 32'd0);
            chk("skid_hold_pc", pc_incr_out, 32'h10);
            chk("skid_hold_valid", 32'(instr_valid), 32'd1);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1);
        #3;
        chk("unskid_pc_incr", pc_incr_out, 32'h14);
        chk("unskid_valid", 32'(instr_valid), 32'd1);
        chk("unskid_addr", imem_addr, 32'h14);
        chk("unskid_req", 32'(imem_req), 32'd1);
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect while the request at 0x20 is still waiting.
        step(1'b0, 1'b1, 32'h400, 1'b0);
        #3;
        chk("pend_redir_valid", 32'(instr_valid), 32'd0);
        chk("pend_redir_addr", imem_addr, 32'h20);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        #3;
        chk("pend_wait_addr", imem_addr, 32'h20);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        #3;
        chk("drop_valid", 32'(instr_valid), 32'd0);
        chk("drop_next_addr", imem_addr, 32'h400);
        step(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect while FULL and stalled.
        step(1'b1, 1'b0, 32'd0, 1'b1);
        #3;
        chk("full_req", 32'(imem_req), 32'd0);
        step(1'b1, 1'b1, 32'h800, 1'b0);
        #3;
        chk("full_redir_valid", 32'(instr_valid), 32'd0);
        chk("full_redir_addr", imem_addr, 32'h800);
        chk("full_redir_req", 32'(imem_req), 32'd1);

        // Wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        #3;
        chk("wrap_pc_incr", pc_incr_out, 32'd0);
        chk("wrap_valid", 32'(instr_valid), 32'd1);
        chk("wrap_addr", imem_addr, 32'd0);

        // Reset in the middle of an outstanding request.
        step(1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(instr_valid), 32'd0);
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_pc_incr", pc_incr_out, 32'd0);
        chk("async_fields", {opcode_out, rs_out, rt_out, rd_out, shamt_out, funct_out}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        rst = 1'b0;
        restart_stream();
        step(1'b0, 1'b0, 32'd0, 1'b1);
        #3;
        chk("rerst_addr", imem_addr, RST_PC);
        chk("rerst_req", 32'(imem_req), 32'd1);
        chk("rerst_valid", 32'(instr_valid), 32'd0);

        // Random traffic: wait states, stalls, redirects (some unaligned, some near wrap).
        for (int i = 0; i < 3000; i++) begin
            s   = ($urandom % 4) == 0;
            r   = ($urandom % 16) == 0;
            rdy = ($urandom % 3) != 0;
            rpc = $urandom;
            if (($urandom % 4) != 0) rpc[1:0] = 2'b00;
            if (($urandom % 8) == 0) rpc = 32'hFFFF_FFF0;
            step(s, r, rpc, rdy);
        end
        repeat (8) step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("enough_presented", 32'(n_pres >= 300), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
